// File: rtl/pp_fifo_gen2_if.sv
// Write/read handshake and status bundle for pp_fifo_gen2.
// The master side drives requests; the slave side (the FIFO) returns data and flags.
interface pp_fifo_gen2_if #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 128
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en;
   logic             clr_err;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             f_empty;
   logic             f_full;
   logic             f_a_empty;
   logic             f_a_full;
   logic [LW-1:0]    level;
   logic             ovf;
   logic             udf;

   modport master (
      output wr_en, wr_data, rd_en, clr_err,
      input  rd_data, rd_valid, f_empty, f_full, f_a_empty, f_a_full, level, ovf, udf
   );

   modport slave (
      input  wr_en, wr_data, rd_en, clr_err,
      output rd_data, rd_valid, f_empty, f_full, f_a_empty, f_a_full, level, ovf, udf
   );
endinterface

// File: rtl/pp_fifo_gen2.sv
// Synchronous FIFO with programmable thresholds, fill level, sticky error flags,
// write-while-full pass-through and optional first-word-fall-through read port.
module pp_fifo_gen2 #(
   parameter int WIDTH     = 48,
   parameter int DEPTH     = 128,
   parameter int AE_THRESH = 1,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int FWFT      = 0
) (
   input logic           clk,
   input logic           rst_n,
   pp_fifo_gen2_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pp_fifo_gen2: DEPTH must be a power of 2 and >= 4");
   end
   if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_thresh
      $error("pp_fifo_gen2: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [LW-1:0]    level_q;
   logic             ovf_q, udf_q;
   logic             empty, full;
   logic             rd_acc, wr_acc;

   assign empty = (level_q == '0);
   assign full  = (level_q == LW'(DEPTH));

   // A read frees the slot the write needs, so a full FIFO still takes a write when popped.
   assign rd_acc = bus.rd_en & ~empty;
   assign wr_acc = bus.wr_en & (~full | rd_acc);

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= bus.wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Set beats clear so an error coincident with clr_err is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (bus.wr_en & ~wr_acc) ovf_q <= 1'b1;
         else if (bus.clr_err)    ovf_q <= 1'b0;
         if (bus.rd_en & empty)   udf_q <= 1'b1;
         else if (bus.clr_err)    udf_q <= 1'b0;
      end
   end

   if (FWFT != 0) begin : g_fwft
      assign bus.rd_data  = empty ? '0 : mem[rd_ptr];
      assign bus.rd_valid = ~empty;
   end else begin : g_reg
      logic [WIDTH-1:0] rd_data_q;
      logic             rd_valid_q;

      // One-cycle data strobe: data returns to zero when no read is accepted.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else if (rd_acc) begin
            rd_data_q  <= mem[rd_ptr];
            rd_valid_q <= 1'b1;
         end else begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
   end

   assign bus.level     = level_q;
   assign bus.f_empty   = empty;
   assign bus.f_full    = full;
   assign bus.f_a_empty = (level_q <= LW'(AE_THRESH));
   assign bus.f_a_full  = (level_q >= LW'(AF_THRESH));
   assign bus.ovf       = ovf_q;
   assign bus.udf       = udf_q;
endmodule

// File: tb/tb_pp_fifo_gen2.sv
// Directed bench for pp_fifo_gen2: registered-read instance plus an FWFT instance.
module tb_pp_fifo_gen2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pp_fifo_gen2_if #(.WIDTH(8), .DEPTH(8)) bus0 ();
   pp_fifo_gen2_if #(.WIDTH(8), .DEPTH(8)) bus1 ();

   pp_fifo_gen2 #(.WIDTH(8), .DEPTH(8), .AE_THRESH(1), .AF_THRESH(7), .FWFT(0)) u_reg (
      .clk(clk), .rst_n(rst_n), .bus(bus0));
   pp_fifo_gen2 #(.WIDTH(8), .DEPTH(8), .AE_THRESH(1), .AF_THRESH(7), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .bus(bus1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus0.wr_en = 0; bus0.wr_data = '0; bus0.rd_en = 0; bus0.clr_err = 0;
      bus1.wr_en = 0; bus1.wr_data = '0; bus1.rd_en = 0; bus1.clr_err = 0;

      // reset state
      #12;
      chk("rst_empty",   32'(bus0.f_empty),   1);
      chk("rst_full",    32'(bus0.f_full),    0);
      chk("rst_a_empty", 32'(bus0.f_a_empty), 1);
      chk("rst_a_full",  32'(bus0.f_a_full),  0);
      chk("rst_level",   32'(bus0.level),     0);
      chk("rst_rd_data", 32'(bus0.rd_data),   0);
      chk("rst_rd_vld",  32'(bus0.rd_valid),  0);
      chk("rst_ovf",     32'(bus0.ovf),       0);
      chk("rst_udf",     32'(bus0.udf),       0);
      rst_n = 1'b1;

      // fill, overflow, drain
      for (int i = 1; i <= 8; i++) begin
         bus0.wr_en = 1; bus0.wr_data = 8'(i);
         tick();
         chk("fill_level",  32'(bus0.level),     32'(i));
         chk("fill_a_full", 32'(bus0.f_a_full),  32'(i >= 7));
         chk("fill_full",   32'(bus0.f_full),    32'(i == 8));
         chk("fill_a_empty",32'(bus0.f_a_empty), 32'(i <= 1));
      end
      bus0.wr_data = 8'h09;
      tick();
      chk("ovf_set",   32'(bus0.ovf),   1);
      chk("ovf_level", 32'(bus0.level), 8);

      // clear collides with a fresh rejected write, then clears alone
      bus0.clr_err = 1; bus0.wr_data = 8'h5A;
      tick();
      chk("ovf_clr_collide", 32'(bus0.ovf), 1);
      bus0.wr_en = 0;
      tick();
      chk("ovf_clr_alone", 32'(bus0.ovf), 0);
      bus0.clr_err = 0;

      bus0.rd_en = 1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk("drain_data", 32'(bus0.rd_data),  32'(i));
         chk("drain_vld",  32'(bus0.rd_valid), 1);
      end
      bus0.rd_en = 0;
      tick();
      chk("drain_vld_off",  32'(bus0.rd_valid), 0);
      chk("drain_data_off", 32'(bus0.rd_data),  0);
      chk("drain_empty",    32'(bus0.f_empty),  1);
      chk("drain_udf",      32'(bus0.udf),      0);

      // write-while-full pass-through, three passes to wrap the pointers
      for (int rep = 0; rep < 3; rep++) begin
         logic [7:0] base;
         base = 8'(16 * (rep + 1));
         bus0.wr_en = 1;
         for (int k = 0; k < 8; k++) begin
            bus0.wr_data = base + 8'(k);
            tick();
         end
         chk("wwf_full", 32'(bus0.f_full), 1);
         bus0.wr_data = 8'hAA; bus0.rd_en = 1;
         tick();
         bus0.wr_en = 0;
         chk("wwf_level", 32'(bus0.level),   8);
         chk("wwf_out",   32'(bus0.rd_data), 32'(base));
         for (int k = 1; k <= 8; k++) begin
            tick();
            chk("wwf_drain", 32'(bus0.rd_data), (k == 8) ? 32'hAA : 32'(base + 8'(k)));
         end
         bus0.rd_en = 0;
         tick();
         chk("wwf_empty", 32'(bus0.f_empty), 1);
      end

      // simultaneous write and read on empty
      bus0.wr_en = 1; bus0.wr_data = 8'h55; bus0.rd_en = 1;
      tick();
      chk("we_udf",   32'(bus0.udf),      1);
      chk("we_level", 32'(bus0.level),    1);
      chk("we_vld",   32'(bus0.rd_valid), 0);
      bus0.wr_en = 0;
      tick();
      chk("we_data", 32'(bus0.rd_data),  32'h55);
      chk("we_vld2", 32'(bus0.rd_valid), 1);
      bus0.rd_en = 0; bus0.clr_err = 1;
      tick();
      bus0.clr_err = 0;
      chk("udf_clr", 32'(bus0.udf), 0);

      // asynchronous reset mid-operation
      bus0.wr_en = 1;
      for (int k = 1; k <= 5; k++) begin
         bus0.wr_data = 8'(8'h60 + k);
         tick();
      end
      bus0.wr_en = 0; bus0.rd_en = 1;
      tick();
      bus0.rd_en = 0;
      chk("pre_rst_data", 32'(bus0.rd_data), 32'h61);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_empty", 32'(bus0.f_empty),  1);
      chk("arst_level", 32'(bus0.level),    0);
      chk("arst_data",  32'(bus0.rd_data),  0);
      chk("arst_vld",   32'(bus0.rd_valid), 0);
      #2 rst_n = 1'b1;
      tick();
      bus0.wr_en = 1; bus0.wr_data = 8'h77;
      tick();
      bus0.wr_en = 0; bus0.rd_en = 1;
      tick();
      bus0.rd_en = 0;
      chk("post_rst_data", 32'(bus0.rd_data), 32'h77);
      tick();
      chk("post_rst_empty", 32'(bus0.f_empty), 1);

      // FWFT instance
      chk("fw_idle_vld", 32'(bus1.rd_valid), 0);
      bus1.wr_en = 1; bus1.wr_data = 8'h33;
      tick();
      bus1.wr_en = 0;
      chk("fw_vld",  32'(bus1.rd_valid), 1);
      chk("fw_data", 32'(bus1.rd_data),  32'h33);
      bus1.rd_en = 1;
      tick();
      bus1.rd_en = 0;
      chk("fw_pop_empty", 32'(bus1.f_empty),  1);
      chk("fw_pop_vld",   32'(bus1.rd_valid), 0);
      chk("fw_pop_data",  32'(bus1.rd_data),  0);
      bus1.wr_en = 1; bus1.wr_data = 8'h44;
      tick();
      bus1.wr_data = 8'h45;
      tick();
      bus1.wr_en = 0;
      chk("fw_head0",  32'(bus1.rd_data), 32'h44);
      chk("fw_level2", 32'(bus1.level),   2);
      bus1.rd_en = 1;
      tick();
      chk("fw_head1", 32'(bus1.rd_data), 32'h45);
      tick();
      bus1.rd_en = 0;
      chk("fw_end_vld", 32'(bus1.rd_valid), 0);
      chk("fw_end_udf", 32'(bus1.udf),      0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
